instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch front end: the requesting side of the instruction memory interface. Owns the PC and drives a byte address to the instruction memory, which returns a 32-bit word combinationally in the same cycle. Registers that word into an IF/ID pipeline register with its PC and a valid bit. Handles stall, branch/jump redirect, a boot bubble after reset, and halt on EBREAK.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding placed in IF/ID (addi x0,x0,0).
HALT_INSTR, 32'h0010_0073, encoding that halts fetch (EBREAK).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hold PC and IF/ID contents this cycle.
redirect_valid  input  1  load redirect_pc as the next PC (taken branch or jal).
redirect_pc  input  32  redirect target, byte address.
imem_addr  output  32  byte address to instruction memory; equals current PC, combinational.
imem_instr  input  32  instruction word returned by memory for imem_addr, same cycle.
if_id_instr  output  32  registered instruction.
if_id_pc  output  32  registered PC of if_id_instr.
if_id_pc_plus4  output  32  registered if_id_pc + 4.
if_id_valid  output  1  IF/ID holds a real instruction.
halted  output  1  fetch frozen after EBREAK.
misalign_err  output  1  sticky; a redirect target had bits [1:0] != 0.
fetch_count  output  32  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset (async, any state, including mid-stall or mid-redirect): pc=RESET_PC, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=4, if_id_valid=0, halted=0, misalign_err=0, fetch_count=0.
- imem_addr = pc at all times, no register stage. Fetch latency is one cycle: the word at pc appears on if_id_* after the next edge.
- FSM states BOOT, RUN, HALT.
- BOOT: exactly one cycle after reset deasserts. PC is held, if_id_valid=0, stall and redirect are ignored. Next state is RUN.
- RUN, priority redirect > stall > normal.
  - redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}. IF/ID <= NOP_INSTR with valid=0, discarding the wrong-path fetch. fetch_count is unchanged. If redirect_pc[1:0] != 0, misalign_err <= 1 (sticky until reset). Redirect wins over a simultaneous stall.
  - stall=1, no redirect: pc and all IF/ID registers hold; fetch_count holds.
  - normal: if_id_instr <= imem_instr, if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_valid <= 1, fetch_count += 1 (wraps at 2^32), pc <= pc+4.
  - PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Halt entry: in RUN, normal case with imem_instr == HALT_INSTR. The EBREAK is captured into IF/ID with valid=1 and counted, pc <= pc+4, state <= HALT, halted <= 1.
  - While stalled, an EBREAK is not captured and HALT is not entered until the stall releases.
  - A redirect in the same cycle takes priority: the EBREAK is discarded and there is no halt.
- HALT: pc frozen; from the next edge if_id_valid=0 with if_id_instr=NOP_INSTR. stall and redirect are ignored. halted=1. Exit only by reset.
- No X propagation: outputs are defined from reset onward regardless of imem_instr contents.

Test Plan:
- Reset with RESET_PC=0, memory preloaded 0x00..0x0C, no stall → cycle after release: valid=0 (BOOT). Then if_id_pc = 0,4,8,C on consecutive edges with matching words; fetch_count=4.
- In RUN at pc=8, stall high 3 cycles → imem_addr stays 8, IF/ID frozen, fetch_count frozen. On release the word at 8 is loaded.
- At pc=0x1C, redirect_valid=1 with redirect_pc=0x0C and stall=1 → next edge: pc=0x0C, if_id_valid=0, if_id_instr=0x00000013. Following edge loads the word at 0x0C.
- redirect_pc=0x0000_0016 → pc=0x14, misalign_err=1. It stays 1 through later fetches until reset.
- Memory word at 0x10 = 0x00100073 → IF/ID gets it with valid=1, halted=1, pc=0x14 frozen, then valid=0. A later redirect to 0x0 is ignored.
- Set pc=0xFFFF_FFFC via redirect, run one normal cycle → pc=0x0000_0000, if_id_pc_plus4=0. Assert reset mid-stall → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory bus between fetch unit and memory
interface instr_fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;

   // fetch side: drives the address, receives the word in the same cycle
   modport master (
      output imem_addr,
      input  imem_instr
   );

   // memory side: decodes the address, returns the word combinationally
   modport slave (
      input  imem_addr,
      output imem_instr
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, IF/ID register, redirect/stall/boot/halt control
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
   parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   instr_fetch_unit_if.master      imem,
   output logic [31:0]             if_id_instr,
   output logic [31:0]             if_id_pc,
   output logic [31:0]             if_id_pc_plus4,
   output logic                    if_id_valid,
   output logic                    halted,
   output logic                    misalign_err,
   output logic [31:0]             fetch_count
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_d, id_pc_d, id_plus4_d, count_d;
   logic        valid_d, misalign_d;

   // memory sees the live PC; no address register stage
   assign imem.imem_addr = pc_q;
   assign halted         = (state_q == HALT);

   // state, PC and IF/ID registers; reset is honoured immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         if_id_instr    <= NOP_INSTR;
         if_id_pc       <= 32'h0000_0000;
         if_id_pc_plus4 <= 32'h0000_0004;
         if_id_valid    <= 1'b0;
         misalign_err   <= 1'b0;
         fetch_count    <= 32'h0000_0000;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_id_instr    <= instr_d;
         if_id_pc       <= id_pc_d;
         if_id_pc_plus4 <= id_plus4_d;
         if_id_valid    <= valid_d;
         misalign_err   <= misalign_d;
         fetch_count    <= count_d;
      end
   end

   // next-state and next register values; redirect beats stall beats a normal fetch
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = if_id_instr;
      id_pc_d    = if_id_pc;
      id_plus4_d = if_id_pc_plus4;
      valid_d    = if_id_valid;
      misalign_d = misalign_err;
      count_d    = fetch_count;
      case (state_q)
         BOOT: begin
            // one dead cycle after reset so memory sees RESET_PC before capture
            valid_d = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               // squash the wrong-path word that memory is returning this cycle
               pc_d    = {redirect_pc[31:2], 2'b00};
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end
            end else if (!stall) begin
               instr_d    = imem.imem_instr;
               id_pc_d    = pc_q;
               id_plus4_d = pc_q + 32'd4;
               valid_d    = 1'b1;
               count_d    = fetch_count + 32'd1;
               pc_d       = pc_q + 32'd4;
               if (imem.imem_instr == HALT_INSTR) begin
                  state_d = HALT;
               end
            end
         end
         HALT: begin
            // EBREAK already handed over; feed bubbles forever
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized check of instr_fetch_unit against a behavioural model
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'h0010_0073;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
   logic        if_id_valid, halted, misalign_err;

   logic [31:0] mem [64];

   instr_fetch_unit_if bus ();

   assign bus.imem_instr = mem[bus.imem_addr[7:2]];

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus.master),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .halted         (halted),
      .misalign_err   (misalign_err),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_ipc, m_plus4, m_cnt;
   logic        m_valid, m_halt, m_mis, m_boot;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      check("imem_addr", bus.imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_pc_plus4", if_id_pc_plus4, m_plus4);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      check("halted", {31'b0, halted}, {31'b0, m_halt});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      check("fetch_count", fetch_count, m_cnt);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_plus4 = 32'h4;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 32'h0; m_boot = 1'b1;
   endtask

   // one clock of the architectural rules, using the memory image directly
   task automatic model_step(input logic s, input logic rv, input logic [31:0] rp);
      logic [31:0] w;
      if (m_boot) begin
         m_boot  = 1'b0;
         m_valid = 1'b0;
      end else if (m_halt) begin
         m_instr = NOP;
         m_valid = 1'b0;
      end else if (rv) begin
         m_pc    = rp & 32'hFFFF_FFFC;
         m_instr = NOP;
         m_valid = 1'b0;
         if (rp % 4 != 0) m_mis = 1'b1;
      end else if (!s) begin
         w       = mem[(m_pc / 4) % 64];
         m_instr = w;
         m_ipc   = m_pc;
         m_plus4 = m_pc + 32'd4;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 32'd1;
         m_pc    = m_pc + 32'd4;
         if (w == HALT) m_halt = 1'b1;
      end
   endtask

   // called at a falling edge: drive, advance one clock, sample at the next falling edge
   task automatic cycle(input logic s, input logic rv, input logic [31:0] rp);
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      model_step(s, rv, rp);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         if (mem[i] == HALT) mem[i] = mem[i] ^ 32'h1;
      end
      reset = 1'b1;
      #2;
      do_reset();

      // boot bubble, then sequential fetch and a three-cycle stall at pc 8
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);

      // redirect together with stall, then a misaligned redirect
      cycle(1'b1, 1'b1, 32'h0000_000C);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0000_0016);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);

      // randomized stall / redirect traffic
      for (int i = 0; i < 300; i++) begin
         logic s, rv;
         logic [31:0] rp;
         s  = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 9) == 0);
         rp = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0) | $urandom_range(0, 255);
         cycle(s, rv, rp);
      end

      // PC wraps modulo 2^32
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b0, 32'h0);
      check("wrap_pc", bus.imem_addr, 32'h0);
      check("wrap_plus4", if_id_pc_plus4, 32'h0);

      // EBREAK at 0x10: stalled first, then captured, then frozen
      mem[4] = HALT;
      cycle(1'b0, 1'b1, 32'h0000_0010);
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      check("halt_instr", if_id_instr, HALT);
      cycle(1'b0, 1'b1, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      check("halt_pc", bus.imem_addr, 32'h0000_0014);

      // redirect in the same cycle as an EBREAK discards it
      do_reset();
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0000_0010);
      cycle(1'b0, 1'b1, 32'h0000_0020);
      cycle(1'b0, 1'b0, 32'h0);

      // asynchronous reset in the middle of a stall
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
